toggle_monitor: RTL and testbench
=================================

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter CNT_W, 8, width of edge_cnt, period and internal counters.
REQ-002 Parameter TIMEOUT, 32, consecutive samples of q without change that declare the input stuck; legal range 2 to 2^CNT_W-1.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rstn  input  1  reset, synchronous, active-low.
REQ-005 Port q  input  1  toggle flip-flop output, same clock domain; no synchronizer.
REQ-006 Port clr  input  1  synchronous clear of edge_cnt and measurement state.
REQ-007 Port edge_cnt  output  CNT_W  saturating count of q transitions, both directions.
REQ-008 Port period  output  CNT_W  last measured rise-to-rise interval in clk cycles.
REQ-009 Port period_vld  output  1  one-cycle pulse when period updates.
REQ-010 Port stuck  output  1  level; q unchanged for TIMEOUT samples.

Function
REQ-011 A sample is the value of q at a rising clk edge; q_d holds the previous sample.
REQ-012 At each edge, rise = q & ~q_d and fall = ~q & q_d; edge = rise | fall.
REQ-013 edge_cnt increments by 1 at the same clock edge that samples the changed q; it saturates at 2^CNT_W-1 and never wraps.
REQ-014 The FSM has exactly three states: IDLE, MEASURE and STUCK.
REQ-015 IDLE: on rise, go to MEASURE and load per_cnt = 1; on fall, stay in IDLE.
REQ-016 MEASURE: per_cnt increments by 1 each cycle, saturating at 2^CNT_W-1.
REQ-017 MEASURE on rise: period <= per_cnt, period_vld = 1 for exactly that cycle, per_cnt <= 1, and the state stays MEASURE.
REQ-018 Consecutive rises at clock edges k and k+n produce period = n; period = 2^CNT_W-1 means at least that value.
REQ-019 idle_cnt resets to 0 on any edge and otherwise increments, in IDLE and MEASURE.
REQ-020 When idle_cnt reaches TIMEOUT-1 without an edge, the next edge-free sample enters STUCK.
REQ-021 STUCK entry sets stuck = 1 at that same clock edge.
REQ-022 STUCK: stuck stays 1 and period_vld stays 0.
REQ-023 STUCK on rise: stuck = 0, go to MEASURE, per_cnt = 1, and period does not update.
REQ-024 STUCK on fall: stuck = 0, go to IDLE.
REQ-025 clr = 1 takes priority over any simultaneous edge: edge_cnt = 0, per_cnt = 0, idle_cnt = 0, stuck = 0, period_vld = 0, state = IDLE.
REQ-026 clr retains period and still updates q_d.
REQ-027 period_vld and stuck are never 1 in the same cycle.

Reset
REQ-028 While rstn = 0 at a clock edge: q_d = 0, state = IDLE, edge_cnt = 0, period = 0, period_vld = 0, stuck = 0, per_cnt = 0, idle_cnt = 0.
REQ-029 Reset mid-measurement discards the partial interval, and the first rise after reset never produces period_vld.
REQ-030 rstn takes priority over clr.

Structure
REQ-031 Shared package toggle_monitor_pkg holds the state enum (IDLE, MEASURE, STUCK) and the CNT_W default.
REQ-032 One sub-module, edge_detect, holds the q_d register and produces rise and fall; all counters and the FSM live in toggle_monitor.

Verification
REQ-033 Directed: rstn low 2 cycles, then t held 1 (q toggles every cycle) -> edge_cnt +1 per cycle; period_vld every 2nd cycle with period = 2.
REQ-034 Directed: t pulsed so q rises every 5 cycles -> period = 5, exactly one period_vld per rise after the first, stuck = 0.
REQ-035 Directed: after reset, t held 0 with TIMEOUT = 32 -> stuck = 1 after 32 edge-free samples; next q rise -> stuck = 0, state MEASURE, no period_vld until the following rise.
REQ-036 Directed: CNT_W = 4, 20 transitions -> edge_cnt holds at 15.
REQ-037 Directed: clr coincident with a rise in MEASURE -> edge_cnt = 0, state IDLE, no period_vld, period unchanged.
REQ-038 Directed: rstn asserted mid-measurement, then q rises twice 3 cycles apart -> only one period_vld, with period = 3.

Source files
------------

// File: rtl/toggle_monitor_pkg.sv
// Shared types and defaults for the toggle monitor.
// Holds the FSM state encoding and default parameter values.
// No logic; imported by the monitor top.
package toggle_monitor_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Registers the previous sample of q and flags rising/falling transitions.
// rise/fall are combinational against the registered previous sample.
// No backpressure; q is sampled every cycle.
module edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic q,
    output logic rise,
    output logic fall
);

    logic q_d;

    // Previous-sample register; clr does not touch it so edges stay coherent.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_d <= 1'b0;
        end else begin
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/toggle_monitor.sv
// Monitors a toggle flop: counts transitions, measures rise-to-rise period, flags a stuck input.
// Outputs update at the clock edge that samples the transition (registered, no extra delay).
// No backpressure; period_vld is a single-cycle pulse with no hold-off.
module toggle_monitor
    import toggle_monitor_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             q,
    input  logic             clr,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

    logic             rise;
    logic             fall;
    logic             edge_any;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_nxt;
    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_nxt;
    logic             period_upd;

    edge_detect u_edge_detect (
        .clk  (clk),
        .rstn (rstn),
        .q    (q),
        .rise (rise),
        .fall (fall)
    );

    assign edge_any = rise | fall;
    assign per_inc  = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
    assign stuck    = (state == STUCK);

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter next values and period capture strobe; clr overrides everything.
    always_comb begin
        state_nxt  = state;
        per_nxt    = per_cnt;
        idle_nxt   = idle_cnt;
        period_upd = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    per_nxt   = CNT_ONE;
                    idle_nxt  = '0;
                end else if (fall) begin
                    idle_nxt  = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt = STUCK;
                    idle_nxt  = '0;
                end else begin
                    idle_nxt  = idle_cnt + CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_upd = 1'b1;
                    per_nxt    = CNT_ONE;
                    idle_nxt   = '0;
                end else if (fall) begin
                    per_nxt    = per_inc;
                    idle_nxt   = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt  = STUCK;
                    per_nxt    = '0;
                    idle_nxt   = '0;
                end else begin
                    per_nxt    = per_inc;
                    idle_nxt   = idle_cnt + CNT_ONE;
                end
            end
            STUCK: begin
                // Recovering from stuck starts a fresh interval; no period is reported.
                if (rise) begin
                    state_nxt = MEASURE;
                    per_nxt   = CNT_ONE;
                end else if (fall) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                per_nxt   = '0;
                idle_nxt  = '0;
            end
        endcase
        if (clr) begin
            state_nxt  = IDLE;
            per_nxt    = '0;
            idle_nxt   = '0;
            period_upd = 1'b0;
        end
    end

    // Measurement counters and period capture; period survives clr.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            per_cnt    <= '0;
            idle_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
        end else begin
            per_cnt    <= per_nxt;
            idle_cnt   <= idle_nxt;
            period_vld <= period_upd;
            if (period_upd) begin
                period <= per_cnt;
            end
        end
    end

    // Saturating transition counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            edge_cnt <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
        end else if (edge_any && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_toggle_monitor.sv
// Directed bench for toggle_monitor with a period scoreboard.
// Inputs driven on the falling edge, outputs sampled away from the rising edge.
// A second instance with CNT_W=4 exercises counter saturation.
module tb_toggle_monitor;
    import toggle_monitor_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       q;
    logic       clr;
    logic [7:0] edge_cnt;
    logic [7:0] period;
    logic       period_vld;
    logic       stuck;
    logic [3:0] edge_cnt4;
    logic [3:0] period4;
    logic       period_vld4;
    logic       stuck4;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    int         vld_cnt  = 0;
    int         base;
    logic [7:0] exp_q[$];

    toggle_monitor #(.CNT_W(8), .TIMEOUT(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .q          (q),
        .clr        (clr),
        .edge_cnt   (edge_cnt),
        .period     (period),
        .period_vld (period_vld),
        .stuck      (stuck)
    );

    toggle_monitor #(.CNT_W(4), .TIMEOUT(15)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .q          (q),
        .clr        (clr),
        .edge_cnt   (edge_cnt4),
        .period     (period4),
        .period_vld (period_vld4),
        .stuck      (stuck4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard: every period_vld pulse must match the next queued period.
    always begin
        @(posedge clk);
        #1;
        if (period_vld === 1'b1) begin
            vld_cnt++;
            chk("vld_expected", 32'(exp_q.size() != 0), 32'd1);
            chk("vld_not_stuck", 32'(stuck), 32'd0);
            if (exp_q.size() != 0) begin
                chk("period", 32'(period), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rstn = 1'b0;
        q    = 1'b0;
        clr  = 1'b0;
        tick();
        tick();
        chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_period_vld", 32'(period_vld), 32'd0);
        chk("rst_stuck", 32'(stuck), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        rstn = 1'b1;

        // q toggles every cycle: one edge per cycle, period 2 on every rise after the first.
        base = vld_cnt;
        for (int i = 1; i <= 20; i++) begin
            q = ~q;
            if (q && i > 1) exp_q.push_back(8'd2);
            tick();
            chk("t1_edge_cnt", 32'(edge_cnt), 32'(i));
        end
        chk("t1_vld_count", 32'(vld_cnt - base), 32'd9);
        chk("t1_period", 32'(period), 32'd2);
        chk("t1_stuck", 32'(stuck), 32'd0);
        chk("sat_edge_cnt4", 32'(edge_cnt4), 32'd15);

        // clr clears counts, keeps period.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("clr_period_kept", 32'(period), 32'd2);
        chk("clr_state", 32'(dut.state), 32'(IDLE));

        // Rise every 5 cycles.
        base = vld_cnt;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                q = (c == 0);
                if (c == 0 && r > 0) exp_q.push_back(8'd5);
                tick();
                chk("t2_stuck", 32'(stuck), 32'd0);
            end
        end
        chk("t2_vld_count", 32'(vld_cnt - base), 32'd4);
        chk("t2_period", 32'(period), 32'd5);
        chk("t2_edge_cnt", 32'(edge_cnt), 32'd10);

        // Reset, then hold q low until stuck.
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        chk("t3_rst_period", 32'(period), 32'd0);
        for (int i = 0; i < 31; i++) tick();
        chk("t3_stuck_31", 32'(stuck), 32'd0);
        tick();
        chk("t3_stuck_32", 32'(stuck), 32'd1);
        chk("t3_state_stuck", 32'(dut.state), 32'(STUCK));
        tick();
        tick();
        tick();
        chk("t3_stuck_hold", 32'(stuck), 32'd1);
        base = vld_cnt;
        q = 1'b1;
        tick();
        chk("t3_stuck_clear", 32'(stuck), 32'd0);
        chk("t3_state_measure", 32'(dut.state), 32'(MEASURE));
        chk("t3_no_vld", 32'(period_vld), 32'd0);
        tick();
        q = 1'b0;
        tick();
        tick();
        chk("t3_vld_none_yet", 32'(vld_cnt - base), 32'd0);
        q = 1'b1;
        exp_q.push_back(8'd4);
        tick();
        chk("t3_vld_one", 32'(vld_cnt - base), 32'd1);
        chk("t3_edge_cnt", 32'(edge_cnt), 32'd3);
        chk("t3_period", 32'(period), 32'd4);

        // clr coincident with a rise in MEASURE.
        base = vld_cnt;
        q = 1'b0;
        tick();
        q   = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("t5_state", 32'(dut.state), 32'(IDLE));
        chk("t5_period_vld", 32'(period_vld), 32'd0);
        chk("t5_period_kept", 32'(period), 32'd4);
        chk("t5_vld_none", 32'(vld_cnt - base), 32'd0);

        // Reset mid-measurement, then two rises 3 cycles apart.
        q = 1'b0;
        tick();
        q = 1'b1;
        tick();
        tick();
        tick();
        rstn = 1'b0;
        q    = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        base = vld_cnt;
        q = 1'b1;
        tick();
        chk("t6_first_rise_no_vld", 32'(period_vld), 32'd0);
        q = 1'b0;
        tick();
        tick();
        q = 1'b1;
        exp_q.push_back(8'd3);
        tick();
        tick();
        tick();
        chk("t6_vld_count", 32'(vld_cnt - base), 32'd1);
        chk("t6_period", 32'(period), 32'd3);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
